// File: rtl/tinycpu_gen.sv
// tinycpu_gen: parametrised stack-machine CPU core with a req/ack memory bus, CALL/RET and traps.
// Define STACK_GUARD_EN to trap stack underflow/overflow; otherwise the stack saturates silently.
module tinycpu_gen #(
    parameter int unsigned DW     = 16,
    parameter int unsigned AW     = 12,
    parameter int unsigned SDEPTH = 8
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          run,
    output logic          mem_req,
    output logic          mem_we,
    output logic [AW-1:0] mem_addr,
    output logic [DW-1:0] mem_wdata,
    input  logic [DW-1:0] mem_rdata,
    input  logic          mem_ack,
    output logic [DW-1:0] out,
    output logic          out_valid,
    output logic          halted,
    output logic          fault,
    output logic [1:0]    fault_code
);
    localparam int unsigned SPW = $clog2(SDEPTH + 1);
    localparam int unsigned IW  = $clog2(SDEPTH);
    localparam logic [SPW-1:0] SPMAX = SPW'(SDEPTH);

    localparam logic [2:0] st_idle   = 3'd0;
    localparam logic [2:0] st_fetch  = 3'd1;
    localparam logic [2:0] st_exec   = 3'd2;
    localparam logic [2:0] st_mem    = 3'd3;
    localparam logic [2:0] st_halted = 3'd4;
    localparam logic [2:0] st_fault  = 3'd5;

    localparam logic [3:0] op_halt  = 4'h0;
    localparam logic [3:0] op_pushi = 4'h1;
    localparam logic [3:0] op_push  = 4'h2;
    localparam logic [3:0] op_pop   = 4'h3;
    localparam logic [3:0] op_jmp   = 4'h4;
    localparam logic [3:0] op_jz    = 4'h5;
    localparam logic [3:0] op_jnz   = 4'h6;
    localparam logic [3:0] op_call  = 4'h7;
    localparam logic [3:0] op_ret   = 4'h8;
    localparam logic [3:0] op_out   = 4'he;
    localparam logic [3:0] op_alu   = 4'hf;

    logic [2:0]     state_q, state_d;
    logic [AW-1:0]  pc_q, pc_d;
    logic [DW-1:0]  ir_q, ir_d;
    logic [SPW-1:0] sp_q, sp_d;
    logic [DW-1:0]  out_q, out_d;
    logic           outv_q, outv_d;
    logic [1:0]     fcode_q, fcode_d;
    logic [DW-1:0]  stk [SDEPTH];

    logic [3:0]     opcode;
    logic [AW-1:0]  operand;
    logic [DW-1:0]  imm;
    logic [4:0]     f;
    logic           illegal;
    logic [DW-1:0]  top, nxt, alu;
    logic [SPW-1:0] sp_pop1, sp_pop2;
    logic           push_en, stk_we;
    logic [SPW-1:0] push_base;
    logic [DW-1:0]  push_val;

    assign opcode  = ir_q[DW-1:DW-4];
    assign operand = ir_q[AW-1:0];
    assign imm     = {{(DW-AW){operand[AW-1]}}, operand};
    assign f       = ir_q[4:0];
    assign illegal = (opcode >= 4'h9) && (opcode <= 4'hd);

    // Empty slots read as zero so unguarded pops on an empty stack see 0.
    assign top     = (sp_q != '0) ? stk[IW'(sp_q - SPW'(1))] : '0;
    assign nxt     = (sp_q >= SPW'(2)) ? stk[IW'(sp_q - SPW'(2))] : '0;
    assign sp_pop1 = (sp_q != '0) ? sp_q - SPW'(1) : '0;
    assign sp_pop2 = (sp_q >= SPW'(2)) ? sp_q - SPW'(2) : '0;

`ifdef STACK_GUARD_EN
    logic need1, need2, need_room, underflow, overflow;
    assign need1     = (opcode inside {op_pop, op_jz, op_jnz, op_ret, op_out})
                       || (opcode == op_alu && f[4]);
    assign need2     = (opcode == op_alu) && !f[4];
    assign need_room = opcode inside {op_pushi, op_push, op_call};
    assign underflow = (need1 && sp_q == '0) || (need2 && sp_q < SPW'(2));
    assign overflow  = need_room && (sp_q == SPMAX);
`endif

    always_comb begin
        alu = top;
        if (f[4]) begin
            case (f[3:0])
                4'h0:    alu = ~top;
                4'h1:    alu = -top;
                default: alu = top;
            endcase
        end else begin
            case (f[3:0])
                4'h0:    alu = nxt + top;
                4'h1:    alu = nxt - top;
                4'h2:    alu = nxt & top;
                4'h3:    alu = nxt | top;
                4'h4:    alu = nxt ^ top;
                4'h5:    alu = {{(DW-1){1'b0}}, nxt == top};
                4'h6:    alu = {{(DW-1){1'b0}}, nxt != top};
                4'h7:    alu = {{(DW-1){1'b0}}, $signed(nxt) < $signed(top)};
                default: alu = '0;
            endcase
        end
    end

    always_comb begin
        state_d   = state_q;
        pc_d      = pc_q;
        ir_d      = ir_q;
        sp_d      = sp_q;
        out_d     = out_q;
        outv_d    = 1'b0;
        fcode_d   = fcode_q;
        push_en   = 1'b0;
        push_base = sp_q;
        push_val  = imm;
        stk_we    = 1'b0;
        case (state_q)
            st_idle, st_halted: if (run) state_d = st_fetch;
            st_fetch: begin
                if (mem_ack) begin
                    ir_d    = mem_rdata;
                    pc_d    = pc_q + AW'(1);
                    state_d = st_exec;
                end
            end
            st_exec: begin
                state_d = st_fetch;
                if (illegal) begin
                    state_d = st_fault;
                    fcode_d = 2'b11;
`ifdef STACK_GUARD_EN
                end else if (underflow) begin
                    state_d = st_fault;
                    fcode_d = 2'b01;
                end else if (overflow) begin
                    state_d = st_fault;
                    fcode_d = 2'b10;
`endif
                end else begin
                    case (opcode)
                        op_halt:  state_d = st_halted;
                        op_pushi: push_en = 1'b1;
                        op_push, op_pop: state_d = st_mem;
                        op_jmp:   pc_d = operand;
                        op_jz: begin
                            sp_d = sp_pop1;
                            if (top == '0) pc_d = operand;
                        end
                        op_jnz: begin
                            sp_d = sp_pop1;
                            if (top != '0) pc_d = operand;
                        end
                        op_call: begin
                            push_en  = 1'b1;
                            push_val = {{(DW-AW){1'b0}}, pc_q};
                            pc_d     = operand;
                        end
                        op_ret: begin
                            pc_d = top[AW-1:0];
                            sp_d = sp_pop1;
                        end
                        op_out: begin
                            out_d  = top;
                            outv_d = 1'b1;
                            sp_d   = sp_pop1;
                        end
                        op_alu: begin
                            push_en   = 1'b1;
                            push_base = f[4] ? sp_pop1 : sp_pop2;
                            push_val  = alu;
                        end
                        default: ;
                    endcase
                end
            end
            st_mem: begin
                if (mem_ack) begin
                    state_d = st_fetch;
                    if (opcode == op_push) begin
                        push_en  = 1'b1;
                        push_val = mem_rdata;
                    end else begin
                        sp_d = sp_pop1;
                    end
                end
            end
            default: ;
        endcase
        // A push into a full stack is dropped and sp saturates.
        if (push_en) begin
            if (push_base < SPMAX) begin
                stk_we = 1'b1;
                sp_d   = push_base + SPW'(1);
            end else begin
                sp_d = SPMAX;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q <= st_idle;
            pc_q    <= '0;
            ir_q    <= '0;
            sp_q    <= '0;
            out_q   <= '0;
            outv_q  <= 1'b0;
            fcode_q <= 2'b00;
        end else begin
            state_q <= state_d;
            pc_q    <= pc_d;
            ir_q    <= ir_d;
            sp_q    <= sp_d;
            out_q   <= out_d;
            outv_q  <= outv_d;
            fcode_q <= fcode_d;
        end
    end

    always_ff @(posedge clk) begin
        if (rst_n && stk_we) stk[IW'(push_base)] <= push_val;
    end

    assign mem_req    = (state_q == st_fetch) || (state_q == st_mem);
    assign mem_we     = (state_q == st_mem) && (opcode == op_pop);
    assign mem_addr   = (state_q == st_fetch) ? pc_q : (state_q == st_mem) ? operand : '0;
    assign mem_wdata  = mem_we ? top : '0;
    assign out        = out_q;
    assign out_valid  = outv_q;
    assign halted     = (state_q == st_halted);
    assign fault      = (state_q == st_fault);
    assign fault_code = fcode_q;
endmodule
